main_control_fsm: RTL and testbench
===================================

MAIN_CONTROL_FSM -- requirements
Module: main_control_fsm

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: CLK  in  1  clock, rising-edge active; RST_n  in  1  asynchronous reset, active low.
REQ-002 opcode  in  7  instruction bits [6:0], held stable by the instruction register after FETCH.
REQ-003 BrTaken  in  1  branch condition from the ALU, already resolved per funct3 by ALU_CONTROL.
REQ-004 PCWrite  out  1  PC load enable.
REQ-005 AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-006 MemWrite  out  1  data memory write enable.
REQ-007 IRWrite  out  1  instruction register load enable.
REQ-008 RegWrite  out  1  register file write enable.
REQ-009 ResultSrc  out  2  result select: 00 = ALUOut, 01 = memory data, 10 = ALU result.
REQ-010 ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1, 11 = zero.
REQ-011 ALUSrcB  out  2  ALU B select: 00 = rs2, 01 = immediate, 10 = constant 4.
REQ-012 ALUOp  out  3  encoding to ALU_CONTROL: 000 = R-type, 001 = branch, 010 = add (load/store/address), 011 = I-type ALU, 100 = LUI/AUIPC.
REQ-013 instr_done  out  1  one-cycle pulse in the final state of each instruction.
REQ-014 illegal  out  1  sticky flag indicating an unsupported opcode.
REQ-015 state  out  4  current state code, for debug.

Function
REQ-016 The block SHALL be a Moore FSM with these state codes: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXEC_R=6, EXEC_I=7, ALUWB=8, BRANCH=9, JAL=10, UPPER=11, ILLEGAL=15; codes 12-14 SHALL go to FETCH.
REQ-017 Transitions SHALL be:
- FETCH -> DECODE.
- DECODE, by opcode: 0000011/0100011 -> MEMADR; 0110011 -> EXEC_R; 0010011 -> EXEC_I; 1100011 -> BRANCH; 1101111 -> JAL; 0110111/0010111 -> UPPER; any other opcode -> ILLEGAL.
- MEMADR -> MEMREAD if opcode[5]=0, else MEMWRITE.
- MEMREAD -> MEMWB.
- EXEC_R, EXEC_I, JAL, UPPER -> ALUWB.
- MEMWB, MEMWRITE, ALUWB, BRANCH -> FETCH.
- ILLEGAL -> ILLEGAL until reset.
REQ-018 Every output not listed for a state SHALL be 0.
REQ-019 Per-state outputs SHALL be:
- FETCH: IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=010, ResultSrc=10, PCUpdate=1.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=010.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=010.
- MEMREAD: AdrSrc=1, ResultSrc=00.
- MEMWRITE: AdrSrc=1, MemWrite=1.
- EXEC_R: ALUSrcA=10, ALUSrcB=00, ALUOp=000.
- EXEC_I: ALUSrcA=10, ALUSrcB=01, ALUOp=011.
- MEMWB: ResultSrc=01, RegWrite=1.
- ALUWB: ResultSrc=00, RegWrite=1.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=001, ResultSrc=00, Branch=1.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=010, ResultSrc=00, PCUpdate=1.
- UPPER: ALUSrcA=11 for LUI or 01 for AUIPC, ALUSrcB=01, ALUOp=100.
REQ-020 PCWrite SHALL equal PCUpdate OR (Branch AND BrTaken), computed combinationally in the same cycle.
REQ-021 instr_done SHALL be 1 in MEMWB, MEMWRITE, ALUWB and BRANCH, and 0 in every other state.
REQ-022 illegal SHALL be 1 exactly when the state is ILLEGAL; all write enables SHALL be 0 in ILLEGAL.
REQ-023 Instruction latency SHALL be: load 5 cycles; store 4; R-type, I-type, JAL and LUI/AUIPC 4; branch 3.
REQ-024 BrTaken SHALL be ignored outside BRANCH.
REQ-025 opcode SHALL be sampled only in DECODE, MEMADR and UPPER.

Reset
REQ-026 While RST_n=0, the state SHALL be FETCH and PCWrite, MemWrite, IRWrite, RegWrite, instr_done and illegal SHALL be forced to 0.
REQ-027 On release of RST_n, the FSM SHALL start in FETCH with FETCH outputs active on the first rising edge.
REQ-028 Assertion of RST_n mid-instruction, or in ILLEGAL, SHALL abort the instruction immediately with no further write-enable pulse.

Verification
REQ-029 Load (opcode 0000011) SHALL produce states 0,1,2,3,4; RegWrite=1 only in cycle 5 with ResultSrc=01; instr_done=1 only in cycle 5.
REQ-030 Store (0100011) SHALL produce states 0,1,2,5; MemWrite=1 and AdrSrc=1 only in cycle 4; RegWrite=0 throughout.
REQ-031 Branch (1100011) with BrTaken=1 in BRANCH SHALL give PCWrite=1 in cycle 3; the same stimulus with BrTaken=0 SHALL give PCWrite=0; BrTaken=1 forced during DECODE SHALL not raise PCWrite.
REQ-032 R-type (0110011) SHALL give ALUOp=000 in EXEC_R; I-type (0010011) SHALL give ALUOp=011; LUI (0110111) SHALL give ALUSrcA=11 and ALUOp=100; AUIPC (0010111) SHALL give ALUSrcA=01.
REQ-033 Opcode 1111111 SHALL give illegal=1 from cycle 3 onward, held for 10 cycles with all enables 0; RST_n pulsed low SHALL return the state to FETCH.
REQ-034 RST_n driven low during MEMREAD SHALL force the state to 0 asynchronously, with no RegWrite pulse before the next FETCH.

Source files
------------

// File: rtl/main_control_fsm.sv
// ---------------------------------------------------------------------------
// main_control_fsm
//   Moore control FSM for a multi-cycle RV32I datapath. Each instruction
//   walks FETCH -> DECODE -> class-specific states and returns to FETCH.
//   An unsupported opcode parks the FSM in ILLEGAL until reset.
//
// Ports
//   CLK        in   rising-edge clock
//   RST_n      in   asynchronous reset, active low
//   opcode     in   [6:0] instruction opcode from the instruction register
//   BrTaken    in   branch condition, already resolved by ALU_CONTROL
//   PCWrite    out  PC load enable (PCUpdate | Branch & BrTaken)
//   AdrSrc     out  memory address select: 0 = PC, 1 = ALUOut
//   MemWrite   out  data memory write enable
//   IRWrite    out  instruction register load enable
//   RegWrite   out  register file write enable
//   ResultSrc  out  [1:0] 00 = ALUOut, 01 = memory data, 10 = ALU result
//   ALUSrcA    out  [1:0] 00 = PC, 01 = OldPC, 10 = rs1, 11 = zero
//   ALUSrcB    out  [1:0] 00 = rs2, 01 = immediate, 10 = constant 4
//   ALUOp      out  [2:0] 000 R, 001 branch, 010 add, 011 I-ALU, 100 LUI/AUIPC
//   instr_done out  high in the last state of every instruction
//   illegal    out  high while parked in ILLEGAL
//   state      out  [3:0] current state code, for debug
// ---------------------------------------------------------------------------
module main_control_fsm (
    input  logic       CLK,
    input  logic       RST_n,
    input  logic [6:0] opcode,
    input  logic       BrTaken,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUOp,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_UPPER    = 4'd11,
        S_ILLEGAL  = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BRNCH = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    state_t cur_state;
    state_t nxt_state;

    // Raw Moore decodes before reset gating.
    logic       pc_update;
    logic       branch;
    logic       adr_src_r;
    logic       mem_write_r;
    logic       ir_write_r;
    logic       reg_write_r;
    logic       done_r;
    logic       illegal_r;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) cur_state <= S_FETCH;
        else        cur_state <= nxt_state;
    end

    // -----------------------------------------------------------------------
    // Next-state logic. opcode is only looked at in DECODE, MEMADR and
    // UPPER; everywhere else the path is fixed.
    // -----------------------------------------------------------------------
    always_comb begin
        nxt_state = S_FETCH;
        case (cur_state)
            S_FETCH:    nxt_state = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: nxt_state = S_MEMADR;
                    OP_RTYPE:          nxt_state = S_EXEC_R;
                    OP_ITYPE:          nxt_state = S_EXEC_I;
                    OP_BRNCH:          nxt_state = S_BRANCH;
                    OP_JAL:            nxt_state = S_JAL;
                    OP_LUI, OP_AUIPC:  nxt_state = S_UPPER;
                    default:           nxt_state = S_ILLEGAL;
                endcase
            end
            // opcode[5] separates store (0100011) from load (0000011)
            S_MEMADR:   nxt_state = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  nxt_state = S_MEMWB;
            S_EXEC_R,
            S_EXEC_I,
            S_JAL,
            S_UPPER:    nxt_state = S_ALUWB;
            S_MEMWB,
            S_MEMWRITE,
            S_ALUWB,
            S_BRANCH:   nxt_state = S_FETCH;
            S_ILLEGAL:  nxt_state = S_ILLEGAL;
            // unused codes 12-14 recover to FETCH
            default:    nxt_state = S_FETCH;
        endcase
    end

    // -----------------------------------------------------------------------
    // Moore output decode
    // -----------------------------------------------------------------------
    always_comb begin
        pc_update   = 1'b0;
        branch      = 1'b0;
        adr_src_r   = 1'b0;
        mem_write_r = 1'b0;
        ir_write_r  = 1'b0;
        reg_write_r = 1'b0;
        done_r      = 1'b0;
        illegal_r   = 1'b0;
        ResultSrc   = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        ALUOp       = 3'b000;
        case (cur_state)
            S_FETCH: begin
                ir_write_r = 1'b1;
                ALUSrcA    = 2'b00;
                ALUSrcB    = 2'b10;
                ALUOp      = 3'b010;
                ResultSrc  = 2'b10;
                pc_update  = 1'b1;
            end
            S_DECODE: begin
                // OldPC + imm precomputes the branch/jump target
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ALUOp   = 3'b010;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 3'b010;
            end
            S_MEMREAD: begin
                adr_src_r = 1'b1;
                ResultSrc = 2'b00;
            end
            S_MEMWRITE: begin
                adr_src_r   = 1'b1;
                mem_write_r = 1'b1;
                done_r      = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc   = 2'b01;
                reg_write_r = 1'b1;
                done_r      = 1'b1;
            end
            S_EXEC_R: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b00;
                ALUOp   = 3'b000;
            end
            S_EXEC_I: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 3'b011;
            end
            S_ALUWB: begin
                ResultSrc   = 2'b00;
                reg_write_r = 1'b1;
                done_r      = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b00;
                ALUOp     = 3'b001;
                ResultSrc = 2'b00;
                branch    = 1'b1;
                done_r    = 1'b1;
            end
            S_JAL: begin
                // link value OldPC + 4; PC takes the target from ALUOut
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ALUOp     = 3'b010;
                ResultSrc = 2'b00;
                pc_update = 1'b1;
            end
            S_UPPER: begin
                // LUI (opcode[5]=1) adds imm to zero, AUIPC adds imm to OldPC
                ALUSrcA = opcode[5] ? 2'b11 : 2'b01;
                ALUSrcB = 2'b01;
                ALUOp   = 3'b100;
            end
            S_ILLEGAL: begin
                illegal_r = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Enables are gated by RST_n so nothing pulses while reset is held,
    // even though the state register already reads FETCH.
    // -----------------------------------------------------------------------
    assign PCWrite    = RST_n & (pc_update | (branch & BrTaken));
    assign AdrSrc     = adr_src_r;
    assign MemWrite   = RST_n & mem_write_r;
    assign IRWrite    = RST_n & ir_write_r;
    assign RegWrite   = RST_n & reg_write_r;
    assign instr_done = RST_n & done_r;
    assign illegal    = RST_n & illegal_r;
    assign state      = cur_state;

endmodule

// File: tb/tb_main_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_main_control_fsm
//   Randomized instruction stream against a reference model of the control
//   sequence. The driver pushes one expected output vector per cycle; a
//   monitor on the falling edge pops and compares against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_main_control_fsm;

    logic       CLK = 1'b0;
    logic       RST_n;
    logic [6:0] opcode;
    logic       BrTaken;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ALUOp;
    logic       instr_done, illegal;
    logic [3:0] state;

    main_control_fsm dut (
        .CLK(CLK), .RST_n(RST_n), .opcode(opcode), .BrTaken(BrTaken),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .instr_done(instr_done), .illegal(illegal), .state(state)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, adr, mw, irw, rw;
        logic [1:0] rs, sa, sb;
        logic [2:0] op;
        logic       done, ill;
    } vec_t;

    vec_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    localparam logic [6:0] LEGAL [9] = '{7'b0000011, 7'b0100011, 7'b0110011,
                                        7'b0010011, 7'b1100011, 7'b1101111,
                                        7'b0110111, 7'b0010111, 7'b1100011};

    // ---------------- reference model ----------------
    // State sequence of one instruction, listed by instruction class.
    function automatic int path_len(input logic [6:0] opc);
        case (opc)
            7'b0000011: return 5;
            7'b1100011: return 3;
            7'b0100011, 7'b0110011, 7'b0010011,
            7'b1101111, 7'b0110111, 7'b0010111: return 4;
            default: return 3;
        endcase
    endfunction

    function automatic int path_state(input logic [6:0] opc, input int s);
        int seq [5];
        case (opc)
            7'b0000011: seq = '{0, 1, 2, 3, 4};
            7'b0100011: seq = '{0, 1, 2, 5, 0};
            7'b0110011: seq = '{0, 1, 6, 8, 0};
            7'b0010011: seq = '{0, 1, 7, 8, 0};
            7'b1100011: seq = '{0, 1, 9, 0, 0};
            7'b1101111: seq = '{0, 1, 10, 8, 0};
            7'b0110111, 7'b0010111: seq = '{0, 1, 11, 8, 0};
            default:    seq = '{0, 1, 15, 15, 15};
        endcase
        return seq[s];
    endfunction

    // Control table: what the datapath must see in a given state.
    function automatic vec_t model_out(input int st, input logic [6:0] opc,
                                       input logic brt);
        vec_t v = '0;
        v.st = st[3:0];
        case (st)
            0:  begin v.irw = 1; v.pcw = 1; v.sb = 2; v.op = 2; v.rs = 2; end
            1:  begin v.sa = 1; v.sb = 1; v.op = 2; end
            2:  begin v.sa = 2; v.sb = 1; v.op = 2; end
            3:  begin v.adr = 1; end
            4:  begin v.rs = 1; v.rw = 1; v.done = 1; end
            5:  begin v.adr = 1; v.mw = 1; v.done = 1; end
            6:  begin v.sa = 2; end
            7:  begin v.sa = 2; v.sb = 1; v.op = 3; end
            8:  begin v.rw = 1; v.done = 1; end
            9:  begin v.sa = 2; v.op = 1; v.pcw = brt; v.done = 1; end
            10: begin v.sa = 1; v.sb = 2; v.op = 2; v.pcw = 1; end
            11: begin v.sa = (opc == 7'b0110111) ? 2'd3 : 2'd1; v.sb = 1; v.op = 4; end
            15: begin v.ill = 1; end
            default: ;
        endcase
        return v;
    endfunction

    // While reset is low: FETCH muxes, every enable and flag low.
    function automatic vec_t reset_vec();
        vec_t v = '0;
        v.sb = 2; v.op = 2; v.rs = 2;
        return v;
    endfunction

    // ---------------- checking ----------------
    task automatic check_vec(input string nm, input vec_t act, input vec_t exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s t=%0t act st=%0d pcw%b adr%b mw%b irw%b rw%b rs%b sa%b sb%b op%b done%b ill%b | exp st=%0d pcw%b adr%b mw%b irw%b rw%b rs%b sa%b sb%b op%b done%b ill%b",
                      nm, $time, act.st, act.pcw, act.adr, act.mw, act.irw, act.rw,
                      act.rs, act.sa, act.sb, act.op, act.done, act.ill,
                      exp.st, exp.pcw, exp.adr, exp.mw, exp.irw, exp.rw,
                      exp.rs, exp.sa, exp.sb, exp.op, exp.done, exp.ill);
    endtask

    function automatic vec_t dut_vec();
        vec_t v;
        v = '{st: state, pcw: PCWrite, adr: AdrSrc, mw: MemWrite, irw: IRWrite,
              rw: RegWrite, rs: ResultSrc, sa: ALUSrcA, sb: ALUSrcB, op: ALUOp,
              done: instr_done, ill: illegal};
        return v;
    endfunction

    // Monitor: one expected vector per cycle, compared mid-cycle.
    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            vec_t e;
            e = exp_q.pop_front();
            check_vec("cycle", dut_vec(), e);
        end
    end

    // ---------------- driver ----------------
    // brt_mode: 0 random BrTaken, 1 high in DECODE / low in BRANCH,
    // 2 low in DECODE / high in BRANCH. Entered at posedge+1 in FETCH.
    task automatic run_instr(input logic [6:0] opc, input int brt_mode,
                             input int extra_ill);
        int n = path_len(opc);
        for (int s = 0; s < n + extra_ill; s++) begin
            int st = path_state(opc, (s < n) ? s : n - 1);
            // opcode is not sampled in FETCH, so feed it garbage there
            opcode = (s == 0) ? 7'($urandom) : opc;
            case (brt_mode)
                1:       BrTaken = (st == 1);
                2:       BrTaken = (st == 9);
                default: BrTaken = 1'($urandom);
            endcase
            exp_q.push_back(model_out(st, opc, BrTaken));
            @(posedge CLK); #1;
        end
    endtask

    task automatic reset_cycles(input int n);
        RST_n = 1'b0;
        for (int i = 0; i < n; i++) begin
            BrTaken = 1'($urandom);
            exp_q.push_back(reset_vec());
            @(posedge CLK); #1;
        end
        RST_n = 1'b1;
    endtask

    function automatic logic is_legal(input logic [6:0] opc);
        foreach (LEGAL[i]) if (LEGAL[i] == opc) return 1'b1;
        return 1'b0;
    endfunction

    initial begin
        RST_n = 1'b0; opcode = '0; BrTaken = 1'b0;
        @(posedge CLK); #1;
        reset_cycles(2);

        // random legal instruction stream
        for (int i = 0; i < 60; i++)
            run_instr(LEGAL[$urandom_range(0, 8)], 0, 0);

        // branch directed cases
        run_instr(7'b1100011, 1, 0);
        run_instr(7'b1100011, 2, 0);
        run_instr(7'b0110111, 0, 0);
        run_instr(7'b0010111, 0, 0);

        // reset in MEMREAD: drop RST_n mid-cycle, state must snap to FETCH
        for (int s = 0; s < 3; s++) begin
            opcode = (s == 0) ? 7'h55 : 7'b0000011;
            BrTaken = 1'($urandom);
            exp_q.push_back(model_out(path_state(7'b0000011, s), 7'b0000011, BrTaken));
            @(posedge CLK); #1;
        end
        RST_n = 1'b0;
        #1;
        n_chk++;
        if (state == 4'd0 && !RegWrite && !PCWrite && !IRWrite) n_pass++;
        else $display("FAIL async_abort act st=%0d rw=%b pcw=%b irw=%b exp st=0 rw=0 pcw=0 irw=0",
                      state, RegWrite, PCWrite, IRWrite);
        exp_q.push_back(reset_vec());
        @(posedge CLK); #1;
        reset_cycles(1);
        run_instr(7'b0000011, 0, 0);

        // illegal 1111111, parked 10 more cycles, then reset
        run_instr(7'b1111111, 0, 10);
        reset_cycles(1);
        run_instr(7'b0110011, 0, 0);

        // a random non-RV32I opcode
        begin
            logic [6:0] bad;
            do bad = 7'($urandom); while (is_legal(bad));
            run_instr(bad, 0, 3);
        end
        reset_cycles(1);
        for (int i = 0; i < 10; i++)
            run_instr(LEGAL[$urandom_range(0, 8)], 0, 0);

        @(negedge CLK); #1;
        n_chk++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain act=%0d pending exp=0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

endmodule
